// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: instruction codes, datapath
// widths, FSM state encodings and the record latched for a memory access.
// These are the values a MIPS.vh header would carry, packaged so every file
// imports one source instead of redefining widths locally.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  // Datapath widths
  localparam int OP_LENGTH    = 6;
  localparam int REG_LENGTH   = 32;
  localparam int REG_ADDR_LEN = 5;

  // Instruction codes seen by MEM (MIPS primary opcodes for LW/SW)
  localparam logic [OP_LENGTH-1:0] CMD_ADD = 6'b000000;
  localparam logic [OP_LENGTH-1:0] CMD_LW  = 6'b100011;
  localparam logic [OP_LENGTH-1:0] CMD_SW  = 6'b101011;

  // FSM state encodings
  localparam int STATE_LEN = 2;
  localparam logic [STATE_LEN-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_LEN-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_LEN-1:0] ST_ERR    = 2'd2;

  // Everything the stage must remember while the memory access is in flight.
  typedef struct packed {
    logic                    is_sw;
    logic [REG_LENGTH-1:0]   addr;   // already word-aligned
    logic [REG_LENGTH-1:0]   wdata;
    logic [REG_ADDR_LEN-1:0] rd;
    logic                    wr;     // already cleared when rd == 0
  } mem_req_t;

  function automatic logic is_mem_op(input logic [OP_LENGTH-1:0] op);
    return (op == CMD_LW) || (op == CMD_SW);
  endfunction

  // The memory is word addressed; the two byte-offset bits never leave MEM.
  function automatic logic [REG_LENGTH-1:0] word_addr(input logic [REG_LENGTH-1:0] addr);
    return {addr[REG_LENGTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Bundles every non-clock signal of the MEM stage: EX-side inputs, the
// memory request/acknowledge bus, the upstream stall and the registered
// write-back to WB.
//
// Handshake: memReq_o is raised in the first ACCESS cycle and held, with
// memWe_o/memAddr_o/memWdata_o constant, until the cycle in which memAck_i
// is seen high (a one-cycle strobe, memRdata_i valid with it) or until the
// timeout fires. memAck_i while memReq_o is low is ignored. While stall_o is
// high the EX side must hold op_i and the other EX inputs stable; the held
// instruction is accepted in the first IDLE cycle after the stall drops.
//
// Modports:
//   master - the MEM stage itself
//   slave  - the surroundings (EX/WB/memory model)
// ---------------------------------------------------------------------------
interface mem_stage_if;
  import mem_stage_pkg::*;

  // EX side
  logic [OP_LENGTH-1:0]    op_i;
  logic [REG_LENGTH-1:0]   aluData_i;
  logic [REG_LENGTH-1:0]   storeData_i;
  logic [REG_ADDR_LEN-1:0] regcAddr_i;
  logic                    regcWr_i;

  // memory side
  logic                    memAck_i;
  logic [REG_LENGTH-1:0]   memRdata_i;
  logic                    memReq_o;
  logic                    memWe_o;
  logic [REG_LENGTH-1:0]   memAddr_o;
  logic [REG_LENGTH-1:0]   memWdata_o;

  // pipeline control and write-back
  logic                    stall_o;
  logic [REG_LENGTH-1:0]   regcData_o;
  logic [REG_ADDR_LEN-1:0] regcAddr_o;
  logic                    regcWr_o;
  logic                    busErr_o;

  modport master (
    input  op_i, aluData_i, storeData_i, regcAddr_i, regcWr_i,
    input  memAck_i, memRdata_i,
    output memReq_o, memWe_o, memAddr_o, memWdata_o,
    output stall_o, regcData_o, regcAddr_o, regcWr_o, busErr_o
  );

  modport slave (
    output op_i, aluData_i, storeData_i, regcAddr_i, regcWr_i,
    output memAck_i, memRdata_i,
    input  memReq_o, memWe_o, memAddr_o, memWdata_o,
    input  stall_o, regcData_o, regcAddr_o, regcWr_o, busErr_o
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
// Counts the cycles an access has waited for its acknowledge.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous reset, active-low
//   clr    - synchronous clear (held while the stage is idle, so the count
//            is 0 in the first ACCESS cycle)
//   en     - increment this cycle
//   expire - high while the count equals TIMEOUT-1
//
// Parameter TIMEOUT: legal 2..255, so an 8-bit count always suffices.
// ---------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage. Non-memory instructions pass straight to the
// write-back registers with one cycle of latency. LW/SW are latched, the
// stage enters ACCESS and stalls upstream until the memory acknowledges or
// the request times out (one-cycle ERR with a busErr_o pulse).
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous reset, active-low
//   bus       - mem_stage_if.master (EX inputs, memory bus, stall, WB)
//   dbg_state - current FSM state (ST_IDLE/ST_ACCESS/ST_ERR)
//
// Parameter TIMEOUT (2..255): ACCESS cycles without acknowledge before the
// request is abandoned.
//
// Build option MEM_ALIGN_CHECK_EN: when defined, a LW/SW whose byte address
// is not word aligned goes straight to ERR without issuing a request. When
// undefined, the two low address bits are dropped and the access proceeds.
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_if.master          bus,
  output logic [STATE_LEN-1:0] dbg_state
);

  logic [STATE_LEN-1:0]    state;
  logic [STATE_LEN-1:0]    state_nxt;
  mem_req_t                req_q;

  logic                    new_mem;
  logic                    misaligned;
  logic                    in_access;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    expire;

  logic [REG_LENGTH-1:0]   regc_data;
  logic [REG_ADDR_LEN-1:0] regc_addr;
  logic                    regc_wr;

  assign new_mem   = is_mem_op(bus.op_i);
  assign in_access = (state == ST_ACCESS);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (bus.aluData_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The count sits at 0 throughout IDLE, which gives the clear-on-entry
  // behaviour without a separate entry pulse.
  assign cnt_clr = (state == ST_IDLE);
  assign cnt_en  = in_access && !bus.memAck_i;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (expire)
  );

  // Next-state logic. Ack is tested before expire so an acknowledge that
  // lands on the final allowed cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (new_mem) begin
          state_nxt = misaligned ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.memAck_i) begin
          state_nxt = ST_IDLE;
        end else if (expire) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Access latch: captured only when IDLE accepts a LW/SW, so the memory
  // bus stays constant for the whole ACCESS period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
    end else if ((state == ST_IDLE) && new_mem) begin
      req_q.is_sw <= (bus.op_i == CMD_SW);
      req_q.addr  <= word_addr(bus.aluData_i);
      req_q.wdata <= bus.storeData_i;
      req_q.rd    <= bus.regcAddr_i;
      req_q.wr    <= bus.regcWr_i && (bus.regcAddr_i != '0);
    end
  end

  // Write-back registers. Register 0 is never written, whatever EX asks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regc_data <= '0;
      regc_addr <= '0;
      regc_wr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_mem) begin
            regc_wr <= 1'b0;
          end else begin
            regc_data <= bus.aluData_i;
            regc_addr <= bus.regcAddr_i;
            regc_wr   <= bus.regcWr_i && (bus.regcAddr_i != '0);
          end
        end
        ST_ACCESS: begin
          if (bus.memAck_i) begin
            if (!req_q.is_sw) begin
              regc_data <= bus.memRdata_i;
            end
            regc_addr <= req_q.rd;
            regc_wr   <= !req_q.is_sw && req_q.wr;
          end else begin
            regc_wr <= 1'b0;
          end
        end
        default: begin
          regc_wr <= 1'b0;
        end
      endcase
    end
  end

  // Bus outputs are decoded from state, so an asynchronous reset drops the
  // request and the stall immediately.
  assign bus.memReq_o   = in_access;
  assign bus.memWe_o    = in_access && req_q.is_sw;
  assign bus.memAddr_o  = in_access ? req_q.addr  : '0;
  assign bus.memWdata_o = in_access ? req_q.wdata : '0;
  assign bus.stall_o    = (state == ST_ACCESS) || (state == ST_ERR);
  assign bus.busErr_o   = (state == ST_ERR);

  assign bus.regcData_o = regc_data;
  assign bus.regcAddr_o = regc_addr;
  assign bus.regcWr_o   = regc_wr;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Inputs are driven just after the
// falling edge and outputs are sampled at the falling edge, half a cycle
// away from the rising edge the design uses. Expected write-back records
// come from a transaction-level model (what each instruction should leave
// in WB) held in exp_q; expected access length and error outcome are worked
// out from the ack cycle and TIMEOUT with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  logic [STATE_LEN-1:0] dbg_state;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // record = {wr, rd[4:0], data[31:0]}
  logic [37:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  function automatic logic [37:0] wb_rec(input logic wr, input logic [4:0] rd,
                                         input logic [31:0] data);
    return {wr && (rd != 5'd0), rd, data};
  endfunction

  function automatic logic [OP_LENGTH-1:0] rand_alu_op();
    logic [OP_LENGTH-1:0] op;
    do op = OP_LENGTH'($urandom_range(0, 63));
    while (op == CMD_LW || op == CMD_SW);
    return op;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_ex(input logic [OP_LENGTH-1:0] op, input logic [31:0] data,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic wr);
    bus.op_i        = op;
    bus.aluData_i   = data;
    bus.storeData_i = sdata;
    bus.regcAddr_i  = rd;
    bus.regcWr_i    = wr;
  endtask

  // Compare the WB outputs against the oldest expected record. When no
  // write is expected only the enable is meaningful.
  task automatic check_wb(input string name);
    logic [37:0] exp;
    logic [37:0] got;
    exp = exp_q.pop_front();
    got = {bus.regcWr_o, bus.regcAddr_o, bus.regcData_o};
    checks++;
    if (exp[37]) begin
      if (got !== exp) $display("FAIL %s: wb got %h expected %h", name, got, exp);
      else passed++;
    end else begin
      if (bus.regcWr_o !== 1'b0) $display("FAIL %s: regcWr got %b expected 0", name, bus.regcWr_o);
      else passed++;
    end
  endtask

  task automatic run_alu(input logic [31:0] data, input logic [4:0] rd, input logic wr);
    drive_ex(rand_alu_op(), data, $urandom, rd, wr);
    exp_q.push_back(wb_rec(wr, rd, data));
    @(posedge clk); @(negedge clk);
    check_wb("alu_wb");
    checks++;
    if ({bus.stall_o, bus.memReq_o, bus.busErr_o} !== 3'b000)
      $display("FAIL alu_ctrl: stall/req/err got %b expected 000",
               {bus.stall_o, bus.memReq_o, bus.busErr_o});
    else passed++;
  endtask

  // One LW/SW. ack_idx is the ACCESS cycle (0-based) carrying memAck_i;
  // ack_idx >= TIMEOUT means no ack. n_* is the ALU instruction EX holds
  // during the stall; it must complete one cycle after the stage is idle.
  task automatic run_mem(input logic is_sw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic wr, input int ack_idx,
                         input logic [31:0] rdata, input logic [31:0] n_data,
                         input logic [4:0] n_rd, input logic n_wr);
    logic bad_align;
    logic acked;
    logic [31:0] exp_addr;
    bad_align = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    bad_align = (addr[1:0] != 2'b00);
`endif
    exp_addr = addr & 32'hFFFF_FFFC;
    acked = 1'b0;
    drive_ex(is_sw ? CMD_SW : CMD_LW, addr, wdata, rd, wr);
    @(posedge clk); @(negedge clk);
    drive_ex(rand_alu_op(), n_data, $urandom, n_rd, n_wr);
    if (bad_align) begin
      checks++;
      if ({bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o} !== 4'b0110)
        $display("FAIL align_err: req/err/stall/wr got %b expected 0110",
                 {bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o});
      else passed++;
    end else begin
      for (int cyc = 0; cyc < TIMEOUT && !acked; cyc++) begin
        checks++;
        if ({bus.memReq_o, bus.memWe_o, bus.memAddr_o, bus.memWdata_o, bus.stall_o,
             bus.busErr_o, bus.regcWr_o} !== {1'b1, is_sw, exp_addr, wdata, 1'b1, 1'b0, 1'b0})
          $display("FAIL access_c%0d: req=%b we=%b addr=%h wdata=%h stall=%b err=%b wr=%b expected 1 %b %h %h 1 0 0",
                   cyc, bus.memReq_o, bus.memWe_o, bus.memAddr_o, bus.memWdata_o, bus.stall_o,
                   bus.busErr_o, bus.regcWr_o, is_sw, exp_addr, wdata);
        else passed++;
        if (cyc == ack_idx) begin
          bus.memAck_i   = 1'b1;
          bus.memRdata_i = rdata;
          acked = 1'b1;
        end else begin
          bus.memRdata_i = $urandom;
        end
        @(posedge clk); @(negedge clk);
        bus.memAck_i = 1'b0;
      end
      if (ack_idx < TIMEOUT) begin
        exp_q.push_back(is_sw ? 38'd0 : wb_rec(wr, rd, rdata));
        check_wb(is_sw ? "sw_wb" : "lw_wb");
        checks++;
        if ({bus.memReq_o, bus.stall_o, bus.busErr_o} !== 3'b000)
          $display("FAIL done_ctrl: req/stall/err got %b expected 000",
                   {bus.memReq_o, bus.stall_o, bus.busErr_o});
        else passed++;
      end else begin
        checks++;
        if ({bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o} !== 4'b0110)
          $display("FAIL timeout_err: req/err/stall/wr got %b expected 0110",
                   {bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o});
        else passed++;
      end
    end
    if (bad_align || ack_idx >= TIMEOUT) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o} !== 4'b0000)
        $display("FAIL err_exit: req/err/stall/wr got %b expected 0000",
                 {bus.memReq_o, bus.busErr_o, bus.stall_o, bus.regcWr_o});
      else passed++;
    end
    // held instruction is sampled on the next edge
    exp_q.push_back(wb_rec(n_wr, n_rd, n_data));
    @(posedge clk); @(negedge clk);
    check_wb("held_wb");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_ex(CMD_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.memAck_i   = 1'b0;
    bus.memRdata_i = 32'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.memReq_o, bus.memWe_o, bus.memAddr_o, bus.memWdata_o, bus.stall_o,
         bus.regcData_o, bus.regcAddr_o, bus.regcWr_o, bus.busErr_o, dbg_state} !== '0)
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h stall=%b data=%h rd=%0d wr=%b err=%b st=%0d expected all 0",
               bus.memReq_o, bus.memWe_o, bus.memAddr_o, bus.memWdata_o, bus.stall_o,
               bus.regcData_o, bus.regcAddr_o, bus.regcWr_o, bus.busErr_o, dbg_state);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_alu_passthrough();
    run_alu(32'h0000_0005, 5'd3, 1'b1);
    run_alu($urandom, 5'd0, 1'b1);          // r0 never written
    run_alu($urandom, 5'd17, 1'b0);
    for (int i = 0; i < 6; i++) run_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom));
  endtask

  task automatic test_lw();
    run_mem(1'b0, 32'h100, $urandom, 5'd8, 1'b1, 2, 32'hDEAD_BEEF, $urandom, 5'd9, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_mem(1'b1, 32'h40, 32'h1234_5678, 5'd4, 1'b1, 0, $urandom, 32'h0000_0077, 5'd5, 1'b1);
  endtask

  task automatic test_timeout();
    run_mem(1'b0, 32'h200, $urandom, 5'd6, 1'b1, TIMEOUT + 10, $urandom, 32'h0000_0011, 5'd7, 1'b1);
    run_mem(1'b0, 32'h204, $urandom, 5'd6, 1'b1, TIMEOUT - 1, 32'hCAFE_F00D, 32'h0000_0022, 5'd2, 1'b1);
  endtask

  task automatic test_ack_ignored();
    bus.memAck_i   = 1'b1;
    bus.memRdata_i = 32'hBAD0_BAD0;
    run_alu(32'h0000_1234, 5'd12, 1'b1);
    bus.memAck_i = 1'b0;
  endtask

  task automatic test_align();
    run_mem(1'b0, 32'h102, $urandom, 5'd10, 1'b1, 1, 32'h0BAD_CAFE, 32'h0000_0033, 5'd11, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0)
        run_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom));
      else
        run_mem(1'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, TIMEOUT + 2),
                $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_access();
    drive_ex(CMD_LW, 32'h300, $urandom, 5'd13, 1'b1);
    @(posedge clk); @(negedge clk);
    drive_ex(CMD_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.memReq_o, bus.stall_o} !== 2'b11)
      $display("FAIL pre_reset: req/stall got %b expected 11", {bus.memReq_o, bus.stall_o});
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.memReq_o, bus.stall_o, bus.regcWr_o, bus.busErr_o, bus.memAddr_o, dbg_state} !== '0)
      $display("FAIL async_reset: req=%b stall=%b wr=%b err=%b addr=%h st=%0d expected all 0",
               bus.memReq_o, bus.stall_o, bus.regcWr_o, bus.busErr_o, bus.memAddr_o, dbg_state);
    else passed++;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    run_alu(32'h0000_A5A5, 5'd7, 1'b1);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_alu_passthrough();
    test_lw();
    test_back_to_back();
    test_timeout();
    test_ack_ignored();
    test_align();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
